// File: rtl/lvg_pkg.sv
// Shared types and helpers for the LVG-32 result write-back path.
package lvg_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;

  localparam int LVG_N      = 4;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;

  // Beat k maps to (k/N, k%N) row-major, or the swapped pair when transposed.
  function automatic rc_t beat_to_rc(input logic [3:0] k, input logic transpose);
    rc_t rc;
    if (transpose) begin
      rc.row = 2'(int'(k) % LVG_N);
      rc.col = 2'(int'(k) / LVG_N);
    end else begin
      rc.row = 2'(int'(k) / LVG_N);
      rc.col = 2'(int'(k) % LVG_N);
    end
    return rc;
  endfunction

endpackage

// File: rtl/result_writer.sv
// Snapshots a 4x4 result tile on start and streams it as 16 valid/ready word writes.
// First beat one cycle after start; beats hold while wr_ready is low; done one cycle after the last handshake.
module result_writer
  import lvg_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          transpose,
  input  logic [AW-1:0] base_addr,
  input  logic [DW-1:0] r11, r12, r13, r14,
  input  logic [DW-1:0] r21, r22, r23, r24,
  input  logic [DW-1:0] r31, r32, r33, r34,
  input  logic [DW-1:0] r41, r42, r43, r44,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done
);

  localparam int         BEATS = N * N;
  localparam logic [3:0] LAST  = 4'(BEATS - 1);

  wr_state_t     state;
  logic [3:0]    k;
  logic          tr;
  logic [DW-1:0] mat [16];
  logic [3:0]    k_nxt;
  rc_t           rc_nxt;
  logic          capture;

  assign capture = (state == IDLE) && start;
  assign k_nxt   = k + 4'd1;

  always_comb begin
    rc_nxt = beat_to_rc(k_nxt, tr);
  end

  // Capture buffer needs no reset; it is always reloaded before it is read.
  always_ff @(posedge clk) begin
    if (capture) begin
      mat <= '{r11, r12, r13, r14,
               r21, r22, r23, r24,
               r31, r32, r33, r34,
               r41, r42, r43, r44};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      tr       <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tr       <= transpose;
            k        <= '0;
            wr_addr  <= base_addr;
            // Beat 0 is element (0,0) in either order, so take it straight from the input.
            wr_data  <= r11;
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (k == LAST) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              k       <= k_nxt;
              wr_addr <= wr_addr + AW'(WORD_BYTES);
              wr_data <= mat[{rc_nxt.row, rc_nxt.col}];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
